// File: rtl/pipe_skid.sv
// pipe_skid: two-entry skid buffer between RV32 pipeline stages.
// Accepts words under a valid/ready handshake, holds up to two while the
// downstream stage stalls, and re-presents them in strict FIFO order.
// out_data comes straight from a register, and in_ready is decoded from
// state only, so no combinational path runs from out_ready to in_ready.
// Optional feature: define PIPE_SKID_STALL_CNT_EN to build a saturating
// counter of downstream stall cycles on stall_cnt (tied to 0 otherwise).
module pipe_skid #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    input  logic         out_ready,
    output logic [15:0]  stall_cnt
);

    // EMPTY: no words; ONE: main register valid; FULL: main and skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t       state;
    logic [N-1:0] skid_q;
    logic         accept;
    logic         pop;

    // Handshake flags are decoded from the state register only.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Occupancy FSM and data movement; flush overrides every transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            // NOTE: the data registers are reset as well because out_data is
            // visible at the port and must read as zero after reset.
            out_data <= '0;
            skid_q   <= '0;
        end else if (flush) begin
            // Words accepted or popped this cycle are dropped; data is left as is.
            state <= EMPTY;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_data <= in_data;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        out_data <= in_data;
                    end else if (accept) begin
                        skid_q <= in_data;
                        state  <= FULL;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        out_data <= skid_q;
                        state    <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    // Saturating count of cycles where a valid word waits on downstream;
    // only reset clears it, a flush leaves it intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule
